// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Provides the loader state encoding, instruction width and the NOP word.
package imem_loader_pkg;

    localparam int INSTR_W = 32;

    // Returned for any fetch that does not hit a loaded word.
    localparam logic [INSTR_W-1:0] NOP_DEFAULT = 32'hD503201F;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } ld_state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x W words, one synchronous write port and
// one asynchronous read port. Contents are not reset.
// Ports:
//   CLK   in  clock for the write port
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address (combinational read)
//   rdata out read data
module imem_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int W      = 32
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader and instruction memory front-end for the single-cycle core.
// Streams a program into memory, holds the core in reset, then serves fetches.
// Ports:
//   CLK, resetl            clock and async active-low reset
//   load_valid/ready/data  instruction word stream (valid/ready handshake)
//   load_last, startpc_in  end-of-program marker and start PC sampled with it
//   reload                 restart loading (only acted on while running)
//   core_resetl, startpc   reset and start PC driven into the core
//   fetch_pc, instruction  combinational fetch port
//   load_count, overflow   words stored, sticky dropped-word flag
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                 DEPTH       = 64,
    parameter int                 ADDR_W      = 6,
    parameter int                 HOLD_CYCLES = 2,
    parameter logic [INSTR_W-1:0] NOP_WORD    = NOP_DEFAULT
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    input  logic [63:0]        startpc_in,
    input  logic               reload,
    output logic               core_resetl,
    output logic [63:0]        startpc,
    input  logic [63:0]        fetch_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W:0]    load_count,
    output logic               overflow
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(HOLD_CYCLES - 1);

    ld_state_t          state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [HC_W-1:0]    hold_cnt;

    logic               accept;
    logic               full;
    logic               wr_en;

    logic [63:0]        word_idx;
    logic               hit;
    logic [INSTR_W-1:0] rd_data;

    assign load_ready = (state == ST_LOAD);
    assign accept     = load_valid && load_ready;
    assign full       = (load_count == FULL_CNT);
    // Once full, words are still accepted (and dropped) so the
    // producer can always reach its last word.
    assign wr_en      = accept && !full;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            load_count  <= '0;
            overflow    <= 1'b0;
            core_resetl <= 1'b0;
            startpc     <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (wr_en) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        load_count <= load_count + 1'b1;
                    end
                    if (accept && full) begin
                        overflow <= 1'b1;
                    end
                    if (accept && load_last) begin
                        startpc  <= startpc_in;
                        hold_cnt <= HOLD_INIT;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state       <= ST_RUN;
                        core_resetl <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        core_resetl <= 1'b0;
                        wr_ptr      <= '0;
                        load_count  <= '0;
                        overflow    <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (INSTR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (fetch_pc[ADDR_W+1:2]),
        .rdata (rd_data)
    );

    // Full-width compare so high PC bits cannot alias onto low words;
    // gating on load_count hides never-written memory.
    assign word_idx    = fetch_pc >> 2;
    assign hit         = (fetch_pc[1:0] == 2'b00) &&
                         (word_idx < 64'(load_count));
    assign instruction = hit ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Linear sequence of load, hold, run, reload and async-reset scenarios.
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        CLK;
    logic        resetl;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic [63:0] startpc_in;
    logic        reload;
    logic        core_resetl;
    logic [63:0] startpc;
    logic [63:0] fetch_pc;
    logic [31:0] instruction;
    logic [6:0]  load_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    imem_loader dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .startpc_in  (startpc_in),
        .reload      (reload),
        .core_resetl (core_resetl),
        .startpc     (startpc),
        .fetch_pc    (fetch_pc),
        .instruction (instruction),
        .load_count  (load_count),
        .overflow    (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag,
                         input logic [63:0] pc,
                         input logic [31:0] exp);
        fetch_pc = pc;
        #1;
        chk(tag, 64'(instruction), 64'(exp));
    endtask

    initial begin
        resetl     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        startpc_in = '0;
        reload     = 1'b0;
        fetch_pc   = '0;
        #12;
        chk("rst_core_resetl", 64'(core_resetl), 64'd0);
        chk("rst_load_count", 64'(load_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_startpc", startpc, 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        fetch("rst_fetch0", 64'h0, NOP);
        resetl = 1'b1;
        step();

        // Test 1: 12 words, start PC 0
        for (int i = 0; i < 12; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h9100_0000 | 32'(i);
            load_last  = (i == 11);
            startpc_in = 64'h0;
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("t1_count", 64'(load_count), 64'd12);
        chk("t1_ready_hold", 64'(load_ready), 64'd0);
        chk("t1_cr_e0", 64'(core_resetl), 64'd0);
        step();
        chk("t1_cr_e1", 64'(core_resetl), 64'd0);
        step();
        chk("t1_cr_e2", 64'(core_resetl), 64'd1);
        chk("t1_startpc", startpc, 64'd0);
        fetch("t1_fetch_2c", 64'h2C, 32'h9100_000B);
        fetch("t1_fetch_30", 64'h30, NOP);
        fetch("t1_fetch_0", 64'h0, 32'h9100_0000);

        // Test 4: misaligned and out-of-range high bits
        fetch("t4_fetch_6", 64'h6, NOP);
        fetch("t4_fetch_hi", 64'h1_0000_0000, NOP);
        fetch("t4_fetch_4", 64'h4, 32'h9100_0001);

        // Test 5: reload then 23 words with start PC 0x40
        reload = 1'b1;
        step();
        reload = 1'b0;
        chk("t5_cr_low", 64'(core_resetl), 64'd0);
        chk("t5_count0", 64'(load_count), 64'd0);
        chk("t5_ovf0", 64'(overflow), 64'd0);
        chk("t5_ready", 64'(load_ready), 64'd1);
        fetch("t5_fetch_gated", 64'h0, NOP);
        for (int i = 0; i < 23; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 | 32'(i);
            load_last  = (i == 22);
            startpc_in = (i == 22) ? 64'h40 : 64'h999;
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        step();
        chk("t5_startpc", startpc, 64'h40);
        chk("t5_run", 64'(core_resetl), 64'd1);
        chk("t5_count", 64'(load_count), 64'd23);
        fetch("t5_fetch_58", 64'h58, 32'hA000_0016);
        fetch("t5_fetch_5c", 64'h5C, NOP);

        // Test 2: valid toggles every other cycle, 8 words
        reload = 1'b1;
        step();
        reload = 1'b0;
        for (int c = 0; c < 16; c++) begin
            load_valid = (c % 2 == 0);
            load_data  = (c % 2 == 0) ? (32'hB000_0000 | 32'(c / 2))
                                      : 32'hDEAD_BEEF;
            load_last  = (c == 14) || (c == 13);
            startpc_in = 64'h80;
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("t2_count", 64'(load_count), 64'd8);
        step();
        step();
        chk("t2_run", 64'(core_resetl), 64'd1);
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data  = 32'hC000_0000 | 32'(k);
            step();
        end
        load_valid = 1'b0;
        chk("t2_count_run", 64'(load_count), 64'd8);
        chk("t2_ready_run", 64'(load_ready), 64'd0);
        for (int k = 0; k < 8; k++) begin
            fetch("t2_fetch_k", 64'(k * 4), 32'hB000_0000 | 32'(k));
        end
        fetch("t2_fetch_20", 64'h20, NOP);

        // Test 3: 66 words into 64-deep memory
        reload = 1'b1;
        step();
        reload = 1'b0;
        for (int i = 0; i < 66; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hD000_0000 | 32'(i);
            load_last  = (i == 65);
            startpc_in = 64'h100;
            step();
            if (i == 64) begin
                chk("t3_ovf_first", 64'(overflow), 64'd1);
                chk("t3_ready_full", 64'(load_ready), 64'd1);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_count", 64'(load_count), 64'd64);
        fetch("t3_fetch_fc", 64'hFC, 32'hD000_003F);
        fetch("t3_fetch_100", 64'h100, NOP);
        step();
        step();
        chk("t3_run", 64'(core_resetl), 64'd1);
        chk("t3_startpc", startpc, 64'h100);

        // Test 6: async reset mid-load
        reload = 1'b1;
        step();
        reload = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hE000_0000 | 32'(i);
            load_last  = 1'b0;
            step();
        end
        load_valid = 1'b0;
        chk("t6_count5", 64'(load_count), 64'd5);
        #1;
        resetl = 1'b0;
        #1;
        chk("t6_async_cr", 64'(core_resetl), 64'd0);
        chk("t6_async_count", 64'(load_count), 64'd0);
        #1;
        resetl     = 1'b1;
        #1;
        chk("t6_ready", 64'(load_ready), 64'd1);
        load_valid = 1'b1;
        load_data  = 32'hF000_0001;
        load_last  = 1'b1;
        startpc_in = 64'h200;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("t6_count1", 64'(load_count), 64'd1);
        fetch("t6_fetch0", 64'h0, 32'hF000_0001);
        fetch("t6_fetch4", 64'h4, NOP);
        step();
        step();
        chk("t6_run", 64'(core_resetl), 64'd1);
        chk("t6_startpc", startpc, 64'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
